codificador_inmediato: RTL and testbench

CODIFICADOR_INMEDIATO -- requirements
Module: codificador_inmediato

---
 rtl/codificador_pkg.sv | 67 ++++++
 rtl/verificador_rango.sv | 48 ++++
 rtl/codificador_inmediato.sv | 149 ++++++++++++++
 tb/tb_codificador_inmediato.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// codificador_pkg: shared types and constants for the RV32I immediate encoder.
// Holds the instruction-type encodings, the base opcodes, the control FSM
// state type, the captured-request record and the word-packing helper.
`default_nettype none

package codificador_pkg;

    // Instruction format selector carried on tipo_i; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        TIPO_R = 3'd0,
        TIPO_I = 3'd1,
        TIPO_S = 3'd2,
        TIPO_L = 3'd3,
        TIPO_B = 3'd4,
        TIPO_J = 3'd5
    } tipo_e;

    // Base opcodes of the six supported formats.
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;

    // Control FSM: idle/accept, one encode cycle, hold output until taken.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CODIFICA = 2'd1,
        ENTREGA  = 2'd2
    } estado_e;

    // Everything captured from the request port at accept time.
    typedef struct packed {
        logic [2:0]  tipo;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] inmediato;
    } solicitud_t;

    // Packs a request into its RV32I word. Out-of-range immediates are simply
    // truncated to the bits the format carries; illegal types give all zeros.
    // Fields a format does not use are left at zero.
    function automatic logic [31:0] codifica(input solicitud_t s);
        logic [31:0] palabra;
        palabra = '0;
        case (s.tipo)
            TIPO_R: palabra = {s.funct7, s.rs2, s.rs1, s.funct3, s.rd, OP_R};
            TIPO_I: palabra = {s.inmediato[11:0], s.rs1, s.funct3, s.rd, OP_I};
            TIPO_L: palabra = {s.inmediato[11:0], s.rs1, s.funct3, s.rd, OP_L};
            TIPO_S: palabra = {s.inmediato[11:5], s.rs2, s.rs1, s.funct3,
                               s.inmediato[4:0], OP_S};
            TIPO_B: palabra = {s.inmediato[12], s.inmediato[10:5], s.rs2, s.rs1,
                               s.funct3, s.inmediato[4:1], s.inmediato[11], OP_B};
            TIPO_J: palabra = {s.inmediato[20], s.inmediato[10:1], s.inmediato[11],
                               s.inmediato[19:12], s.rd, OP_J};
            default: palabra = '0;
        endcase
        return palabra;
    endfunction

endpackage

`default_nettype wire

// File: rtl/verificador_rango.sv
// verificador_rango: purely combinational range/type checker.
// Flags an immediate that does not fit the selected format (upper bits not a
// sign extension, or a branch/jump offset that is odd) and flags illegal types.
`default_nettype none

module verificador_rango
    import codificador_pkg::*;
#(
    parameter int IMM = 20
) (
    input  logic [2:0]  tipo_i,
    input  logic [31:0] inmediato_i,
    output logic        error_o
);

    // Bits [31:32-IMM] must replicate bit 11 for I/S/L; IMM = 0 checks nothing.
    localparam logic [31:0] MASCARA_ISL = ~(32'hFFFF_FFFF >> IMM);
    // Branch offsets sign-extend from bit 12, jump offsets from bit 20.
    localparam logic [31:0] MASCARA_B   = 32'hFFFF_F000;
    localparam logic [31:0] MASCARA_J   = 32'hFFF0_0000;

    logic fuera_isl;
    logic fuera_b;
    logic fuera_j;

    // A field is out of range when any checked upper bit differs from its sign bit.
    always_comb begin
        fuera_isl = |((inmediato_i ^ {32{inmediato_i[11]}}) & MASCARA_ISL);
        fuera_b   = |((inmediato_i ^ {32{inmediato_i[12]}}) & MASCARA_B);
        fuera_j   = |((inmediato_i ^ {32{inmediato_i[20]}}) & MASCARA_J);
    end

    // Select the rule for the requested format.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        error_o = 1'b0;
        case (tipo_i)
            TIPO_R:                 error_o = 1'b0;
            TIPO_I, TIPO_S, TIPO_L: error_o = fuera_isl;
            TIPO_B:                 error_o = fuera_b | inmediato_i[0];
            TIPO_J:                 error_o = fuera_j | inmediato_i[0];
            default:                error_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/codificador_inmediato.sv
// codificador_inmediato: accepts one instruction description at a time,
// encodes it into an RV32I word in a dedicated cycle and presents it with a
// valid/ready handshake together with a range/type error flag.
// Optional feature: define CONTADOR_DIRECCION_EN to get a running word
// address on direccion_o (starting at DIR_INICIO, +4 per delivered word);
// without it direccion_o is tied to zero and no counter is built.
`default_nettype none

module codificador_inmediato
    import codificador_pkg::*;
#(
    parameter int          IMM        = 20,
    parameter logic [31:0] DIR_INICIO = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valido_i,
    output logic        listo_o,
    input  logic [2:0]  tipo_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] inmediato_i,
    output logic [31:0] instruccion_o,
    output logic        valido_o,
    input  logic        listo_i,
    output logic        error_o,
    output logic [31:0] direccion_o
);

    estado_e     estado_q;
    estado_e     estado_d;
    logic        acepta;
    logic        carga;
    logic        entrega;

    solicitud_t  solicitud_d;
    solicitud_t  solicitud_q;
    logic [31:0] palabra;
    logic        error_rango;
    logic [31:0] instruccion_q;
    logic        error_q;

    assign solicitud_d = '{tipo:      tipo_i,
                           rd:        rd_i,
                           rs1:       rs1_i,
                           rs2:       rs2_i,
                           funct3:    funct3_i,
                           funct7:    funct7_i,
                           inmediato: inmediato_i};

    // State register; reset drops any pending instruction immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        estado_d = estado_q;
        listo_o  = 1'b0;
        valido_o = 1'b0;
        acepta   = 1'b0;
        carga    = 1'b0;
        entrega  = 1'b0;
        case (estado_q)
            OCIOSO: begin
                listo_o = 1'b1;
                if (valido_i) begin
                    acepta   = 1'b1;
                    estado_d = CODIFICA;
                end
            end
            CODIFICA: begin
                carga    = 1'b1;
                estado_d = ENTREGA;
            end
            ENTREGA: begin
                valido_o = 1'b1;
                if (listo_i) begin
                    entrega  = 1'b1;
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Capture the whole request on accept so the port may change afterwards.
    always_ff @(posedge clk_i) begin
        // NOTE: the captured request is pure datapath, only read after a fresh accept, so it carries no reset.
        if (acepta) begin
            solicitud_q <= solicitud_d;
        end
    end

    verificador_rango #(
        .IMM (IMM)
    ) u_verificador_rango (
        .tipo_i      (solicitud_q.tipo),
        .inmediato_i (solicitud_q.inmediato),
        .error_o     (error_rango)
    );

    assign palabra = codifica(solicitud_q);

    // Register the encoded word and its error flag during the encode cycle;
    // they stay put through ENTREGA regardless of listo_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instruccion_q <= '0;
            error_q       <= 1'b0;
        end else if (carga) begin
            instruccion_q <= palabra;
            error_q       <= error_rango;
        end
    end

    assign instruccion_o = instruccion_q;
    assign error_o       = error_q;

`ifdef CONTADOR_DIRECCION_EN
    logic [31:0] direccion_q;

    // Word address of the presented instruction; advances after each
    // delivered word and wraps naturally at the top of the address space.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            direccion_q <= DIR_INICIO;
        end else if (entrega) begin
            direccion_q <= direccion_q + 32'd4;
        end
    end

    assign direccion_o = direccion_q;
`else
    // Fixed at zero; without the counter the start address has no effect.
    assign direccion_o = DIR_INICIO & 32'h0000_0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_codificador_inmediato.sv
// tb_codificador_inmediato: scoreboard bench for codificador_inmediato.
// Driver pushes the expected word/error from a format-level reference model,
// a negedge monitor pops and compares whenever valido_o is presented, and
// also applies back-pressure through listo_i. Honors CONTADOR_DIRECCION_EN.
`timescale 1ns/1ps

module tb_codificador_inmediato;

    localparam logic [31:0] DIR_BASE = 32'hFFFF_FFF0;
`ifdef CONTADOR_DIRECCION_EN
    localparam logic [31:0] DIR_RESET = DIR_BASE;
`else
    localparam logic [31:0] DIR_RESET = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } esperado_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valido_i;
    logic        listo_o;
    logic [2:0]  tipo_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] inmediato_i;
    logic [31:0] instruccion_o;
    logic        valido_o;
    logic        listo_i;
    logic        error_o;
    logic [31:0] direccion_o;

    esperado_t   cola[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Monitor-side state shared with the driver for directed scenarios.
    bit          hold_forever = 1'b0;
    int          force_hold   = 0;
    int          hold         = 0;
    bit          visto        = 1'b0;
    logic [31:0] exp_dir;
    logic [31:0] last_instr;
    logic        last_err;
    logic [31:0] last_dir;

    codificador_inmediato #(
        .IMM        (20),
        .DIR_INICIO (DIR_BASE)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valido_i      (valido_i),
        .listo_o       (listo_o),
        .tipo_i        (tipo_i),
        .rd_i          (rd_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .inmediato_i   (inmediato_i),
        .instruccion_o (instruccion_o),
        .valido_o      (valido_o),
        .listo_i       (listo_i),
        .error_o       (error_o),
        .direccion_o   (direccion_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_checks++;
        if (actual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    // Reference model: RV32I field placement via shifts and masks, range rules
    // as plain signed-integer bounds.
    function automatic esperado_t modelo(input int tipo, input logic [31:0] rd, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [31:0] f3,
                                         input logic [31:0] f7, input logic [31:0] imm);
        esperado_t e;
        int s;
        logic [31:0] comun;
        s = $signed(imm);
        comun = (rs1 << 15) | (f3 << 12);
        e.err = 1'b0;
        case (tipo)
            0: e.instr = (f7 << 25) | (rs2 << 20) | comun | (rd << 7) | 32'h33;
            1, 3: begin
                e.err   = (s < -2048) || (s > 2047);
                e.instr = ((imm & 32'hFFF) << 20) | comun | (rd << 7) | ((tipo == 1) ? 32'h13 : 32'h03);
            end
            2: begin
                e.err   = (s < -2048) || (s > 2047);
                e.instr = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | comun | ((imm & 32'h1F) << 7) | 32'h23;
            end
            4: begin
                e.err   = ((s & 1) != 0) || (s < -4096) || (s > 4095);
                e.instr = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | comun
                        | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            5: begin
                e.err   = ((s & 1) != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
                e.instr = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                        | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
            end
            default: begin
                e.err   = 1'b1;
                e.instr = 32'h0;
            end
        endcase
        return e;
    endfunction

    // Issue one request; starts and ends #1 after a rising edge.
    task automatic emitir(input int tipo, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7, input logic [31:0] imm, input bit ver_latencia);
        int n;
        cola.push_back(modelo(tipo, rd[4:0], rs1[4:0], rs2[4:0], f3[2:0], f7[6:0], imm));
        n = 0;
        while (!listo_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!listo_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL listo_o timeout: got 0, expected 1 within 100 cycles");
        end
        tipo_i      = tipo[2:0];
        rd_i        = rd[4:0];
        rs1_i       = rs1[4:0];
        rs2_i       = rs2[4:0];
        funct3_i    = f3[2:0];
        funct7_i    = f7[6:0];
        inmediato_i = imm;
        valido_i    = 1'b1;
        @(posedge clk_i); #1;
        valido_i    = 1'b0;
        // Scramble the port so a missing capture shows up in the word.
        tipo_i      = 3'($urandom);
        rd_i        = 5'($urandom);
        rs1_i       = 5'($urandom);
        rs2_i       = 5'($urandom);
        funct3_i    = 3'($urandom);
        funct7_i    = 7'($urandom);
        inmediato_i = $urandom;
        if (ver_latencia) begin
            check("valido_o in encode cycle", 32'(valido_o), 32'd0);
            check("listo_o in encode cycle", 32'(listo_o), 32'd0);
            @(posedge clk_i); #1;
            check("valido_o two cycles after accept", 32'(valido_o), 32'd1);
        end
    endtask

    // Monitor and back-pressure source.
    always @(negedge clk_i) begin
        esperado_t e;
        if (rst_i) begin
            listo_i = 1'b0;
            visto   = 1'b0;
            hold    = 0;
            exp_dir = DIR_RESET;
        end else if (valido_o) begin
            if (!visto) begin
                if (cola.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected output: got %h with empty scoreboard", instruccion_o);
                end else begin
                    e = cola[0];
                    check("instruccion_o", instruccion_o, e.instr);
                    check("error_o", 32'(error_o), 32'(e.err));
                    check("direccion_o", direccion_o, exp_dir);
                end
                visto      = 1'b1;
                last_instr = instruccion_o;
                last_err   = error_o;
                last_dir   = direccion_o;
                hold       = (force_hold > 0) ? force_hold : int'($urandom_range(0, 2));
                force_hold = 0;
            end else begin
                check("instruccion_o held", instruccion_o, last_instr);
                check("error_o held", 32'(error_o), 32'(last_err));
                check("direccion_o held", direccion_o, last_dir);
                check("listo_o while presenting", 32'(listo_o), 32'd0);
            end
            if (hold_forever || hold > 0) begin
                listo_i = 1'b0;
                if (hold > 0) hold--;
            end else begin
                listo_i = 1'b1;
                if (cola.size() > 0) void'(cola.pop_front());
                visto = 1'b0;
`ifdef CONTADOR_DIRECCION_EN
                exp_dir = exp_dir + 32'd4;
`endif
            end
        end else begin
            listo_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tipo;
        int n;
        int sel;
        logic [31:0] imm;
        int bordes[10] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 1048574, -1048576, 1048576};

        rst_i = 1'b1; valido_i = 1'b0; listo_i = 1'b0;
        tipo_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; inmediato_i = '0;
        exp_dir = DIR_RESET;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset valido_o", 32'(valido_o), 32'd0);
        check("reset error_o", 32'(error_o), 32'd0);
        check("reset instruccion_o", instruccion_o, 32'd0);
        check("reset direccion_o", direccion_o, DIR_RESET);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("listo_o after reset", 32'(listo_o), 32'd1);

        // Directed words.
        emitir(1, 1, 0, 0, 0, 0, 32'd5, 1'b1);
        check("I imm=5 word", instruccion_o, 32'h0050_0093);
        emitir(2, 0, 1, 2, 2, 0, 32'd8, 1'b1);
        check("S imm=8 word", instruccion_o, 32'h0020_A423);
        emitir(4, 0, 0, 0, 0, 0, -32'sd4, 1'b1);
        check("B imm=-4 word", instruccion_o, 32'hFE00_0EE3);
        emitir(5, 1, 0, 0, 0, 0, 32'h800, 1'b1);
        check("J imm=0x800 word", instruccion_o, 32'h0010_00EF);
        emitir(1, 3, 4, 0, 0, 0, 32'd2048, 1'b1);
        check("I imm=2048 error_o", 32'(error_o), 32'd1);
        emitir(7, 1, 2, 3, 4, 5, 32'd0, 1'b0);

        // Held output for three cycles of back-pressure.
        force_hold = 3;
        emitir(0, 5, 6, 7, 1, 32, 32'h1234_5678, 1'b0);

        // Randomised traffic, boundary values mixed in.
        for (int k = 0; k < 150; k++) begin
            tipo = $urandom_range(0, 7);
            sel  = $urandom_range(0, 3);
            case (sel)
                0: imm = $urandom;
                1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                2: imm = 32'(int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21));
                default: imm = 32'(bordes[$urandom_range(0, 9)]);
            endcase
            emitir(tipo, $urandom, $urandom, $urandom, $urandom, $urandom, imm, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1;
            end
        end

        // Reset while an instruction is being presented.
        n = 0;
        while (cola.size() > 0 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        hold_forever = 1'b1;
        emitir(3, 9, 10, 0, 2, 0, 32'd100, 1'b0);
        n = 0;
        while (!valido_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("valido_o before reset pulse", 32'(valido_o), 32'd1);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        check("valido_o during reset", 32'(valido_o), 32'd0);
        check("instruccion_o during reset", instruccion_o, 32'd0);
        check("direccion_o during reset", direccion_o, DIR_RESET);
        check("listo_o during reset", 32'(listo_o), 32'd1);
        cola.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        hold_forever = 1'b0;
        emitir(1, 1, 0, 0, 0, 0, 32'd5, 1'b1);
        check("I after reset word", instruccion_o, 32'h0050_0093);

        n = 0;
        while (cola.size() > 0 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("scoreboard drained", 32'(cola.size()), 32'd0);
        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
